// File: rtl/output_iface_pkg.sv
// Shared definitions for the datapath readback interface.
//   - Seven-segment glyphs (active-low, bits 6..0 = middle, UL, LL, bottom,
//     LR, UR, top) for hex digits 0..F, plus blank and dash.
//   - hex_to_seg: nibble to glyph lookup.
//   - entry_t: one history entry {z, data[15:0]}.
package output_iface_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef struct packed {
        logic        z;
        logic [15:0] data;
    } entry_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (v)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/output_iface_if.sv
// Signal bundle between the datapath/board and the readback block.
//   capture, datapath_out, Z_out : result and its capture strobe
//   key_prev, key_next           : raw active-low pushbuttons
//   live                         : 1 = show live result, 0 = show history
//   hex0..hex5, z_led            : active-low segment drives and Z LED
// master = the side that drives the inputs (datapath/board), slave = the
// readback block.
interface output_iface_if;
    logic        capture;
    logic [15:0] datapath_out;
    logic        Z_out;
    logic        key_prev;
    logic        key_next;
    logic        live;
    logic [6:0]  hex0;
    logic [6:0]  hex1;
    logic [6:0]  hex2;
    logic [6:0]  hex3;
    logic [6:0]  hex4;
    logic [6:0]  hex5;
    logic        z_led;

    modport master (
        output capture, datapath_out, Z_out, key_prev, key_next, live,
        input  hex0, hex1, hex2, hex3, hex4, hex5, z_led
    );

    modport slave (
        input  capture, datapath_out, Z_out, key_prev, key_next, live,
        output hex0, hex1, hex2, hex3, hex4, hex5, z_led
    );
endinterface

// File: rtl/output_iface_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser followed by a debouncer.
//   clk, reset : clock, asynchronous active-high reset
//   raw        : raw active-low key level
//   press      : one-cycle pulse when the debounced level falls (key pressed)
// The level only changes after DB_CYCLES consecutive cycles of disagreement;
// any return to agreement restarts the count, so short glitches vanish.
module key_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            // synchroniser stages
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            // debounce stage
            press   <= 1'b0;
            if (sync_p1 != level) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    level <= sync_p1;
                    cnt   <= '0;
                    // level is still 1 here only on a 1->0 flip
                    press <= level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/output_iface.sv
// Datapath-to-user readback interface.
//   clk, reset : clock, asynchronous active-high reset
//   bus.slave  : capture/datapath_out/Z_out, key_prev/key_next, live in;
//                hex0..hex5, z_led out (all outputs registered)
// Keeps a DEPTH-entry ring of captured results; the user pages through it
// with the keys (k = 0 is newest). hex4 shows k, hex5 shows the entry count.
module output_iface
    import output_iface_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic           clk,
    input  logic           reset,
    output_iface_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        hist [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] k;
    logic [PW-1:0] k_next;
    logic [PW-1:0] rd_idx;
    logic [CW-1:0] count;
    logic          capture_q;
    logic          cap_edge;
    logic          prev_press;
    logic          next_press;
    entry_t        sel;

    logic [6:0]    hex0_p1, hex1_p1, hex2_p1, hex3_p1, hex4_p1, hex5_p1;
    logic          z_led_p1;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_prev (
        .clk(clk), .reset(reset), .raw(bus.key_prev), .press(prev_press)
    );
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
        .clk(clk), .reset(reset), .raw(bus.key_next), .press(next_press)
    );

    assign cap_edge = bus.capture & ~capture_q;
    // Ring arithmetic wraps naturally in PW bits.
    assign rd_idx   = wr_ptr - PW'(1) - k;
    assign sel      = hist[rd_idx];

    always_comb begin
        k_next = k;
        if (cap_edge) begin
            k_next = '0;
        end else if (prev_press && next_press) begin
            k_next = k;
        end else if (prev_press) begin
            if ((CW'(k) + CW'(1)) < count)
                k_next = k + 1'b1;
        end else if (next_press) begin
            if (k != '0)
                k_next = k - 1'b1;
        end
    end

    // capture / history stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            capture_q <= 1'b1;
            wr_ptr    <= '0;
            count     <= '0;
            k         <= '0;
            for (int i = 0; i < DEPTH; i++)
                hist[i] <= '0;
        end else begin
            capture_q <= bus.capture;
            k         <= k_next;
            if (cap_edge) begin
                hist[wr_ptr] <= '{z: bus.Z_out, data: bus.datapath_out};
                wr_ptr       <= wr_ptr + 1'b1;
                if (count != CW'(DEPTH))
                    count <= count + 1'b1;
            end
        end
    end

    // display stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex0_p1  <= SEG_BLANK;
            hex1_p1  <= SEG_BLANK;
            hex2_p1  <= SEG_BLANK;
            hex3_p1  <= SEG_BLANK;
            hex4_p1  <= SEG_BLANK;
            hex5_p1  <= SEG_BLANK;
            z_led_p1 <= 1'b0;
        end else begin
            hex4_p1 <= hex_to_seg(4'(k));
            hex5_p1 <= hex_to_seg(4'(count));
            if (bus.live) begin
                hex0_p1  <= hex_to_seg(bus.datapath_out[3:0]);
                hex1_p1  <= hex_to_seg(bus.datapath_out[7:4]);
                hex2_p1  <= hex_to_seg(bus.datapath_out[11:8]);
                hex3_p1  <= hex_to_seg(bus.datapath_out[15:12]);
                z_led_p1 <= bus.Z_out;
            end else if (count != '0) begin
                hex0_p1  <= hex_to_seg(sel.data[3:0]);
                hex1_p1  <= hex_to_seg(sel.data[7:4]);
                hex2_p1  <= hex_to_seg(sel.data[11:8]);
                hex3_p1  <= hex_to_seg(sel.data[15:12]);
                z_led_p1 <= sel.z;
            end else begin
                hex0_p1  <= SEG_DASH;
                hex1_p1  <= SEG_DASH;
                hex2_p1  <= SEG_DASH;
                hex3_p1  <= SEG_DASH;
                z_led_p1 <= 1'b0;
            end
        end
    end

    assign bus.hex0  = hex0_p1;
    assign bus.hex1  = hex1_p1;
    assign bus.hex2  = hex2_p1;
    assign bus.hex3  = hex3_p1;
    assign bus.hex4  = hex4_p1;
    assign bus.hex5  = hex5_p1;
    assign bus.z_led = z_led_p1;
endmodule

// File: tb/tb_output_iface.sv
// Directed bench for output_iface (DEPTH=4, DB_CYCLES=16).
module tb_output_iface;
    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G3 = 7'b0110000;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G7 = 7'b1111000;
    localparam logic [6:0] GA = 7'b0001000;
    localparam logic [6:0] GB = 7'b0000011;
    localparam logic [6:0] GE = 7'b0000110;
    localparam logic [6:0] GF = 7'b0001110;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DS = 7'b0111111;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    output_iface_if bus ();

    output_iface #(.DEPTH(4), .DB_CYCLES(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_disp(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0,
                              input logic [6:0] e4, input logic [6:0] e5, input logic ez);
        check_val({tag, ".hex3"}, 32'(bus.hex3), 32'(e3));
        check_val({tag, ".hex2"}, 32'(bus.hex2), 32'(e2));
        check_val({tag, ".hex1"}, 32'(bus.hex1), 32'(e1));
        check_val({tag, ".hex0"}, 32'(bus.hex0), 32'(e0));
        check_val({tag, ".hex4"}, 32'(bus.hex4), 32'(e4));
        check_val({tag, ".hex5"}, 32'(bus.hex5), 32'(e5));
        check_val({tag, ".z_led"}, 32'(bus.z_led), 32'(ez));
    endtask

    // Advance n clock edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_capture(input logic [15:0] d, input logic z);
        bus.datapath_out = d;
        bus.Z_out        = z;
        bus.capture      = 1'b1;
        tick(1);
        bus.capture      = 1'b0;
        tick(2);
    endtask

    task automatic press_prev();
        bus.key_prev = 1'b0;
        tick(24);
        bus.key_prev = 1'b1;
        tick(24);
    endtask

    task automatic press_next();
        bus.key_next = 1'b0;
        tick(24);
        bus.key_next = 1'b1;
        tick(24);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset            = 1'b1;
        bus.capture      = 1'b0;
        bus.datapath_out = 16'h0000;
        bus.Z_out        = 1'b0;
        bus.key_prev     = 1'b1;
        bus.key_next     = 1'b1;
        bus.live         = 1'b0;
        tick(2);
        check_disp("rst", BL, BL, BL, BL, BL, BL, 1'b0);

        reset = 1'b0;
        tick(2);
        check_disp("empty", DS, DS, DS, DS, G0, G0, 1'b0);

        // two captures, newest shown
        do_capture(16'h00A5, 1'b0);
        do_capture(16'h1234, 1'b1);
        check_disp("cap2", G1, G2, G3, G4, G0, G2, 1'b1);

        // one debounced prev press -> older entry
        press_prev();
        check_disp("prev1", G0, G0, GA, G5, G1, G2, 1'b0);

        // 5-cycle glitch ignored
        bus.key_prev = 1'b0;
        tick(5);
        bus.key_prev = 1'b1;
        tick(24);
        check_disp("glitch", G0, G0, GA, G5, G1, G2, 1'b0);

        // next press back to newest
        press_next();
        check_disp("next1", G1, G2, G3, G4, G0, G2, 1'b1);

        // wrap and saturation: buffer ends as {3,4,5,2} with newest = 5
        for (int i = 1; i <= 5; i++)
            do_capture(16'(i), 1'b0);
        check_disp("wrap", G0, G0, G0, G5, G0, G4, 1'b0);
        for (int i = 0; i < 5; i++)
            press_prev();
        check_disp("ksat", G0, G0, G0, G2, G3, G4, 1'b0);

        // k=3 -> 2, then capture edge lands in the same cycle as a prev pulse
        press_next();
        check_disp("k2", G0, G0, G0, G3, G2, G4, 1'b0);
        bus.key_prev = 1'b0;
        tick(18);
        bus.datapath_out = 16'h0777;
        bus.Z_out        = 1'b1;
        bus.capture      = 1'b1;
        tick(1);
        bus.capture      = 1'b0;
        tick(3);
        check_disp("capwins", G0, G7, G7, G7, G0, G4, 1'b1);
        bus.key_prev = 1'b1;
        tick(24);

        // k -> 1, then both keys together leave k alone
        press_prev();
        check_disp("k1", G0, G0, G0, G5, G1, G4, 1'b0);
        bus.key_prev = 1'b0;
        bus.key_next = 1'b0;
        tick(24);
        bus.key_prev = 1'b1;
        bus.key_next = 1'b1;
        tick(24);
        check_disp("both", G0, G0, G0, G5, G1, G4, 1'b0);

        // live mode, then back to the untouched history
        bus.live         = 1'b1;
        bus.datapath_out = 16'hBEEF;
        bus.Z_out        = 1'b1;
        tick(1);
        check_disp("live", GB, GE, GE, GF, G1, G4, 1'b1);
        bus.live = 1'b0;
        tick(2);
        check_disp("hist", G0, G0, G0, G5, G1, G4, 1'b0);

        // reset in the middle of a press
        bus.key_prev = 1'b0;
        tick(10);
        reset = 1'b1;
        #2;
        check_disp("midrst", BL, BL, BL, BL, BL, BL, 1'b0);
        tick(2);
        bus.key_prev = 1'b1;
        reset = 1'b0;
        tick(30);
        check_disp("postrst", DS, DS, DS, DS, G0, G0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
